// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage driving a req/ack data bus, stalling upstream while
// an access is outstanding, and holding the MEM/WB register. Define MEM_TIMEOUT_EN for bus timeout.
module mem_access_stage #(
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mem_flush_i,
   input  logic [DATA_W-1:0] ex_res_i,
   input  logic [DATA_W-1:0] rr_data2_i,
   input  logic [4:0]        rd_i,
   input  logic              regwrite_i,
   input  logic              memread_i,
   input  logic              memwrite_i,
   input  logic              memtoreg_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [DATA_W-1:0] dmem_addr_o,
   output logic [DATA_W-1:0] dmem_wdata_o,
   input  logic [DATA_W-1:0] dmem_rdata_i,
   input  logic              dmem_ack_i,
   output logic              mem_stall_o,
   output logic [DATA_W-1:0] alu_res_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic [4:0]        rd_o,
   output logic              regwrite_o,
   output logic              memtoreg_o,
   output logic              mem_err_o
);

   typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;
   typedef enum logic [1:0] {WB_BUBBLE = 2'd0, WB_PASS = 2'd1, WB_MEM = 2'd2} wb_sel_t;

   state_t            state;
   state_t            state_nxt;
   wb_sel_t           wb_sel;
   logic              memop;
   logic              start;
   logic              req;
   logic              stall;
   logic              timeout;
   logic              flush_pend;
   logic [DATA_W-1:0] addr_lat;
   logic [DATA_W-1:0] wdata_lat;
   logic              we_lat;
   logic [4:0]        rd_lat;
   logic              regwrite_lat;
   logic              memtoreg_lat;

   assign memop = memread_i | memwrite_i;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] to_cnt;

   // Counts ACCESS cycles; restarts from zero whenever a new access is launched.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         to_cnt <= 8'd0;
      end else if (start) begin
         to_cnt <= 8'd0;
      end else if (state == ACCESS) begin
         to_cnt <= to_cnt + 8'd1;
      end else begin
         to_cnt <= to_cnt;
      end
   end

   // An ack in the final allowed cycle takes precedence over the abort.
   assign timeout = (state == ACCESS) && !dmem_ack_i && (to_cnt == TO_LAST);
`else
   logic [7:0] unused_timeout_cycles;
   assign unused_timeout_cycles = 8'(TIMEOUT_CYCLES);
   assign timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = (memop && !mem_flush_i) ? ACCESS : IDLE;
         ACCESS:  state_nxt = (dmem_ack_i || timeout) ? IDLE : ACCESS;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus request, stall and MEM/WB source selection.
   always_comb begin
      req    = 1'b0;
      stall  = 1'b0;
      start  = 1'b0;
      wb_sel = WB_BUBBLE;
      case (state)
         IDLE: begin
            if (memop && !mem_flush_i) begin
               stall = 1'b1;
               start = 1'b1;
            end else if (!mem_flush_i) begin
               wb_sel = WB_PASS;
            end else begin
               wb_sel = WB_BUBBLE;
            end
         end
         ACCESS: begin
            req = 1'b1;
            if (dmem_ack_i) begin
               if (flush_pend || mem_flush_i) begin
                  wb_sel = WB_BUBBLE;
               end else begin
                  wb_sel = WB_MEM;
               end
            end else if (timeout) begin
               stall = 1'b0;
            end else begin
               stall = 1'b1;
            end
         end
         default: begin
            req    = 1'b0;
            stall  = 1'b0;
            start  = 1'b0;
            wb_sel = WB_BUBBLE;
         end
      endcase
   end

   // Access latch and flush-pending flag; the latch holds bus fields stable until ack.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_lat     <= {DATA_W{1'b0}};
         wdata_lat    <= {DATA_W{1'b0}};
         we_lat       <= 1'b0;
         rd_lat       <= 5'd0;
         regwrite_lat <= 1'b0;
         memtoreg_lat <= 1'b0;
         flush_pend   <= 1'b0;
      end else begin
         if (start) begin
            addr_lat     <= ex_res_i;
            wdata_lat    <= rr_data2_i;
            we_lat       <= memwrite_i;
            rd_lat       <= rd_i;
            regwrite_lat <= regwrite_i;
            memtoreg_lat <= memtoreg_i;
         end else begin
            addr_lat     <= addr_lat;
            wdata_lat    <= wdata_lat;
            we_lat       <= we_lat;
            rd_lat       <= rd_lat;
            regwrite_lat <= regwrite_lat;
            memtoreg_lat <= memtoreg_lat;
         end
         if ((state == ACCESS) && !(dmem_ack_i || timeout)) begin
            flush_pend <= flush_pend | mem_flush_i;
         end else begin
            flush_pend <= 1'b0;
         end
      end
   end

   // MEM/WB register and timeout error pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         alu_res_o  <= {DATA_W{1'b0}};
         mem_data_o <= {DATA_W{1'b0}};
         rd_o       <= 5'd0;
         regwrite_o <= 1'b0;
         memtoreg_o <= 1'b0;
         mem_err_o  <= 1'b0;
      end else begin
         case (wb_sel)
            WB_PASS: begin
               alu_res_o  <= ex_res_i;
               mem_data_o <= {DATA_W{1'b0}};
               rd_o       <= rd_i;
               regwrite_o <= regwrite_i;
               memtoreg_o <= memtoreg_i;
            end
            WB_MEM: begin
               alu_res_o  <= addr_lat;
               mem_data_o <= we_lat ? {DATA_W{1'b0}} : dmem_rdata_i;
               rd_o       <= rd_lat;
               regwrite_o <= regwrite_lat;
               memtoreg_o <= memtoreg_lat;
            end
            default: begin
               alu_res_o  <= {DATA_W{1'b0}};
               mem_data_o <= {DATA_W{1'b0}};
               rd_o       <= 5'd0;
               regwrite_o <= 1'b0;
               memtoreg_o <= 1'b0;
            end
         endcase
         mem_err_o <= timeout;
      end
   end

   assign dmem_req_o   = req;
   assign dmem_we_o    = req & we_lat;
   assign dmem_addr_o  = addr_lat;
   assign dmem_wdata_o = wdata_lat;
   assign mem_stall_o  = stall;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
// Timeout scenario is exercised when MEM_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4).
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_flush;
   logic [63:0] ex_res;
   logic [63:0] rr_data2;
   logic [4:0]  rd;
   logic        regwrite;
   logic        memread;
   logic        memwrite;
   logic        memtoreg;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [63:0] dmem_rdata;
   logic        dmem_ack;
   logic        mem_stall;
   logic [63:0] alu_res_o;
   logic [63:0] mem_data_o;
   logic [4:0]  rd_o;
   logic        regwrite_o;
   logic        memtoreg_o;
   logic        mem_err;

   int n_checks = 0;
   int n_errors = 0;
   int rc;
   int sc;

   mem_access_stage #(.DATA_W(64), .TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk), .rst_i(rst), .mem_flush_i(mem_flush),
      .ex_res_i(ex_res), .rr_data2_i(rr_data2), .rd_i(rd),
      .regwrite_i(regwrite), .memread_i(memread), .memwrite_i(memwrite),
      .memtoreg_i(memtoreg),
      .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
      .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata), .dmem_ack_i(dmem_ack),
      .mem_stall_o(mem_stall),
      .alu_res_o(alu_res_o), .mem_data_o(mem_data_o), .rd_o(rd_o),
      .regwrite_o(regwrite_o), .memtoreg_o(memtoreg_o), .mem_err_o(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nop();
      ex_res = 64'd0; rr_data2 = 64'd0; rd = 5'd0;
      regwrite = 1'b0; memread = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
      mem_flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = 64'd0;
   endtask

   // Called at posedge+1; leaves the time at posedge+1 of the cycle after completion.
   task automatic mem_op(input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rdata,
                         input logic [4:0] r, input logic rw, input logic mt,
                         input logic rdn, input logic wrn, input int waits, input int flush_at,
                         output int req_cnt, output int stall_cnt);
      logic req_s;
      logic stall_s;
      int   acc;
      bit   done;
      req_cnt = 0; stall_cnt = 0; acc = 0; done = 1'b0;
      ex_res = addr; rr_data2 = wd; rd = r; regwrite = rw; memtoreg = mt;
      memread = rdn; memwrite = wrn;
      for (int c = 0; c < 64 && !done; c++) begin
         dmem_ack   = dmem_req && (acc == waits);
         dmem_rdata = dmem_ack ? rdata : 64'hBAD0_BAD0_BAD0_BAD0;
         mem_flush  = dmem_req && (acc == flush_at);
         @(negedge clk);
         req_s   = dmem_req;
         stall_s = mem_stall;
         if (c == 0) check("first_cycle_req", {63'd0, req_s}, 64'd0);
         if (req_s) begin
            req_cnt++;
            check("addr_stable", dmem_addr, addr);
            check("we", {63'd0, dmem_we}, {63'd0, wrn});
            if (wrn) check("wdata", dmem_wdata, wd);
         end
         if (stall_s) stall_cnt++;
         if (c > 0) begin
            check("bubble_rw", {63'd0, regwrite_o}, 64'd0);
            check("bubble_rd", {59'd0, rd_o}, 64'd0);
         end
         done = req_s && !stall_s;
         @(posedge clk); #1;
         if (req_s) acc++;
      end
      check("op_done", {63'd0, done}, 64'd1);
      nop();
   endtask

   // Samples the MEM/WB register in the current cycle, then advances to posedge+1.
   task automatic wb_expect(input string tag, input logic [63:0] alu, input logic [63:0] md,
                            input logic [4:0] r, input logic rw, input logic mt);
      @(negedge clk);
      check({tag, "_alu"}, alu_res_o, alu);
      check({tag, "_mdata"}, mem_data_o, md);
      check({tag, "_rd"}, {59'd0, rd_o}, {59'd0, r});
      check({tag, "_rw"}, {63'd0, regwrite_o}, {63'd0, rw});
      check({tag, "_mt"}, {63'd0, memtoreg_o}, {63'd0, mt});
      @(posedge clk); #1;
   endtask

   initial begin
      nop();
      rst = 1'b1;
      ex_res = 64'h100; rd = 5'd3; regwrite = 1'b1; memtoreg = 1'b1; memread = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req", {63'd0, dmem_req}, 64'd0);
      check("rst_alu", alu_res_o, 64'd0);
      check("rst_mdata", mem_data_o, 64'd0);
      check("rst_rw", {63'd0, regwrite_o}, 64'd0);
      check("rst_err", {63'd0, mem_err}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Load held through reset: request starts one cycle after reset release.
      mem_op(64'h100, 64'd0, 64'hABC, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1, rc, sc);
      check("t1_req_cycles", rc, 64'd1);
      check("t1_stall_cycles", sc, 64'd1);
      wb_expect("t1", 64'h100, 64'hABC, 5'd3, 1'b1, 1'b1);

      // ALU op with a stray ack outside ACCESS.
      ex_res = 64'h1234; rd = 5'd5; regwrite = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 64'h77;
      @(negedge clk);
      check("alu_stall", {63'd0, mem_stall}, 64'd0);
      check("alu_req", {63'd0, dmem_req}, 64'd0);
      @(posedge clk); #1;
      nop();
      wb_expect("alu", 64'h1234, 64'd0, 5'd5, 1'b1, 1'b0);

      // Load with three wait cycles.
      mem_op(64'h40, 64'd0, 64'hDEADBEEF, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 3, -1, rc, sc);
      check("ld_req_cycles", rc, 64'd4);
      check("ld_stall_cycles", sc, 64'd4);
      wb_expect("ld", 64'h40, 64'hDEADBEEF, 5'd6, 1'b1, 1'b1);

      // Read and write both set: store wins, load data is discarded.
      mem_op(64'h80, 64'h55, 64'hFFFF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, -1, rc, sc);
      check("st_req_cycles", rc, 64'd1);
      check("st_stall_cycles", sc, 64'd1);
      wb_expect("st", 64'h80, 64'd0, 5'd0, 1'b0, 1'b0);

      // Flush during ACCESS: bus completes, write-back gets a bubble.
      mem_op(64'h200, 64'd0, 64'h1111, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1, rc, sc);
      check("fl_req_cycles", rc, 64'd3);
      check("fl_stall_cycles", sc, 64'd3);
      wb_expect("fl", 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);

      // Back-to-back loads, 2 cycles each.
      mem_op(64'h300, 64'd0, 64'h1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1, rc, sc);
      check("b2b1_stall_cycles", sc, 64'd1);
      mem_op(64'h308, 64'd0, 64'h2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1, rc, sc);
      check("b2b2_stall_cycles", sc, 64'd1);
      wb_expect("b2b", 64'h308, 64'h2, 5'd9, 1'b1, 1'b1);

      // Flushed ALU op becomes a bubble.
      ex_res = 64'h99; rd = 5'd9; regwrite = 1'b1; mem_flush = 1'b1;
      @(posedge clk); #1;
      nop();
      wb_expect("fl_alu", 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);

      // Flushed load never reaches the bus.
      ex_res = 64'h500; memread = 1'b1; mem_flush = 1'b1;
      @(negedge clk);
      check("fl_ld_stall", {63'd0, mem_stall}, 64'd0);
      @(posedge clk); #1;
      nop();
      @(negedge clk);
      check("fl_ld_req", {63'd0, dmem_req}, 64'd0);
      @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
      // No ack: abort after 4 ACCESS cycles, one-cycle error pulse, late ack ignored.
      mem_op(64'h600, 64'd0, 64'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1000, -1, rc, sc);
      check("to_req_cycles", rc, 64'd4);
      check("to_stall_cycles", sc, 64'd4);
      @(negedge clk);
      check("to_err_pulse", {63'd0, mem_err}, 64'd1);
      check("to_req_drop", {63'd0, dmem_req}, 64'd0);
      check("to_wb_rw", {63'd0, regwrite_o}, 64'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b1; dmem_rdata = 64'h4242;
      @(negedge clk);
      check("to_err_once", {63'd0, mem_err}, 64'd0);
      check("to_late_req", {63'd0, dmem_req}, 64'd0);
      @(posedge clk); #1;
      nop();
      wb_expect("to_late", 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);
`else
      // No timeout: ACCESS waits as long as the bus needs, without error.
      mem_op(64'h600, 64'd0, 64'h600D, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 20, -1, rc, sc);
      check("long_req_cycles", rc, 64'd21);
      check("long_stall_cycles", sc, 64'd21);
      @(negedge clk);
      check("long_err", {63'd0, mem_err}, 64'd0);
      check("long_mdata", mem_data_o, 64'h600D);
      @(posedge clk); #1;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
